// File: rtl/zscale_host_mailbox_if.sv
// Core MMIO bus and host tohost/fromhost streams for the Zscale mailbox.
// slave = mailbox side, master = core/host side.
interface zscale_host_mailbox_if #(
  parameter int ADDR_W = 32
);
  logic              io_req_valid;
  logic              io_req_ready;
  logic [ADDR_W-1:0] io_req_addr;
  logic              io_req_write;
  logic [31:0]       io_req_wdata;
  logic              io_resp_valid;
  logic [31:0]       io_resp_rdata;
  logic              io_tohost_valid;
  logic              io_tohost_ready;
  logic [31:0]       io_tohost_bits;
  logic              io_fromhost_valid;
  logic              io_fromhost_ready;
  logic [31:0]       io_fromhost_bits;
  logic              io_exit_valid;
  logic [30:0]       io_exit_code;
  logic              io_wdog_fire;

  modport slave (
    input  io_req_valid,
    input  io_req_addr,
    input  io_req_write,
    input  io_req_wdata,
    input  io_tohost_ready,
    input  io_fromhost_valid,
    input  io_fromhost_bits,
    output io_req_ready,
    output io_resp_valid,
    output io_resp_rdata,
    output io_tohost_valid,
    output io_tohost_bits,
    output io_fromhost_ready,
    output io_exit_valid,
    output io_exit_code,
    output io_wdog_fire
  );

  modport master (
    output io_req_valid,
    output io_req_addr,
    output io_req_write,
    output io_req_wdata,
    output io_tohost_ready,
    output io_fromhost_valid,
    output io_fromhost_bits,
    input  io_req_ready,
    input  io_resp_valid,
    input  io_resp_rdata,
    input  io_tohost_valid,
    input  io_tohost_bits,
    input  io_fromhost_ready,
    input  io_exit_valid,
    input  io_exit_code,
    input  io_wdog_fire
  );
endinterface

// File: rtl/zscale_host_mailbox.sv
// Zscale tohost/fromhost mailbox with exit decode and 1-cycle MMIO response.
// Optional tohost stall watchdog enabled by defining ZSCALE_MBOX_WDOG_EN.
module zscale_host_mailbox #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0000_1000,
  parameter int unsigned       WDOG_CYCLES = 65535
) (
  input logic                  clk,
  input logic                  reset,
  zscale_host_mailbox_if.slave io
);

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_e;

  localparam logic [ADDR_W-1:0] TO_A = BASE_ADDR;
  localparam logic [ADDR_W-1:0] FH_A = BASE_ADDR + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ST_A = BASE_ADDR + ADDR_W'(8);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        to_full_q, to_full_d;
  logic [31:0] to_data_q, to_data_d;
  logic        fh_full_q, fh_full_d;
  logic [31:0] fh_data_q, fh_data_d;
  logic        exit_valid_q, exit_valid_d;
  logic [30:0] exit_code_q, exit_code_d;

  logic        sel_to;
  logic        sel_fh;
  logic        sel_st;
  logic        wr_to;
  logic        acc;
  logic        pop;
  logic        push;
  logic        wdog_fire;
  logic [31:0] status;

  // Word-address decode; byte offset bits are ignored.
  always_comb begin
    sel_to = io.io_req_addr[ADDR_W-1:2] == TO_A[ADDR_W-1:2];
    sel_fh = io.io_req_addr[ADDR_W-1:2] == FH_A[ADDR_W-1:2];
    sel_st = io.io_req_addr[ADDR_W-1:2] == ST_A[ADDR_W-1:2];
    wr_to  = io.io_req_write && sel_to;
  end

  assign io.io_req_ready = (state_q == S_IDLE)
                         && !(wr_to && to_full_q);

  assign acc  = io.io_req_valid && io.io_req_ready;
  assign pop  = to_full_q && io.io_tohost_ready;
  assign push = io.io_fromhost_valid && !fh_full_q;

  assign status = {29'b0, wdog_fire, fh_full_q, to_full_q};

  // Next-state for the request FSM, slots and sticky exit state.
  always_comb begin
    state_d      = acc ? S_RESP : S_IDLE;
    rdata_d      = '0;
    to_full_d    = to_full_q;
    to_data_d    = to_data_q;
    fh_full_d    = fh_full_q;
    fh_data_d    = fh_data_q;
    exit_valid_d = exit_valid_q;
    exit_code_d  = exit_code_q;

    if (acc && !io.io_req_write) begin
      unique case (1'b1)
        sel_to:  rdata_d = to_data_q;
        sel_fh:  rdata_d = fh_full_q ? fh_data_q : '0;
        sel_st:  rdata_d = status;
        default: rdata_d = '0;
      endcase
    end

    if (pop) begin
      to_full_d = 1'b0;
      if (to_data_q[0] && !exit_valid_q) begin
        exit_valid_d = 1'b1;
        exit_code_d  = to_data_q[31:1];
      end
    end

    if (acc && io.io_req_write && sel_to) begin
      to_full_d = 1'b1;
      to_data_d = io.io_req_wdata;
    end

    // Push needs an empty slot and clear needs a full one, so they never
    // collide; a push offered during the clearing read waits a cycle.
    if (push) begin
      fh_full_d = 1'b1;
      fh_data_d = io.io_fromhost_bits;
    end

    if (acc && !io.io_req_write && sel_fh && fh_full_q) begin
      fh_full_d = 1'b0;
    end
  end

  // Mailbox state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rdata_q      <= '0;
      to_full_q    <= 1'b0;
      to_data_q    <= '0;
      fh_full_q    <= 1'b0;
      fh_data_q    <= '0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      to_full_q    <= to_full_d;
      to_data_q    <= to_data_d;
      fh_full_q    <= fh_full_d;
      fh_data_q    <= fh_data_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
    end
  end

`ifdef ZSCALE_MBOX_WDOG_EN
  logic [31:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_fire_q, wdog_fire_d;

  // Count cycles the host leaves a pending word untaken; saturate at limit.
  always_comb begin
    wdog_cnt_d  = wdog_cnt_q;
    wdog_fire_d = wdog_fire_q;
    if (pop) begin
      wdog_cnt_d = '0;
    end else if (to_full_q && !io.io_tohost_ready) begin
      if (wdog_cnt_q != WDOG_CYCLES) begin
        wdog_cnt_d = wdog_cnt_q + 32'd1;
      end
    end
    if (wdog_cnt_d == WDOG_CYCLES) begin
      wdog_fire_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt_q  <= '0;
      wdog_fire_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_fire_q <= wdog_fire_d;
    end
  end

  assign wdog_fire = wdog_fire_q;
`else
  // No watchdog: constant 0 (the parameter term folds away).
  assign wdog_fire = 1'b0 & (WDOG_CYCLES != 0);
`endif

  assign io.io_resp_valid     = (state_q == S_RESP);
  assign io.io_resp_rdata     = rdata_q;
  assign io.io_tohost_valid   = to_full_q;
  assign io.io_tohost_bits    = to_data_q;
  assign io.io_fromhost_ready = !fh_full_q;
  assign io.io_exit_valid     = exit_valid_q;
  assign io.io_exit_code      = exit_code_q;
  assign io.io_wdog_fire      = wdog_fire;

endmodule

// File: tb/tb_zscale_host_mailbox.sv
// Directed bench for zscale_host_mailbox: MMIO table plus stall, exit,
// reset, read-clear and watchdog sequences.
module tb_zscale_host_mailbox;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  zscale_host_mailbox_if #(.ADDR_W(32)) bus ();

  zscale_host_mailbox #(
    .ADDR_W(32),
    .BASE_ADDR(BASE),
    .WDOG_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          push;
    logic [31:0] pdata;
    bit          wr;
    logic [3:0]  off;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.io_req_valid      = 1'b0;
    bus.io_req_addr       = '0;
    bus.io_req_write      = 1'b0;
    bus.io_req_wdata      = '0;
    bus.io_tohost_ready   = 1'b0;
    bus.io_fromhost_valid = 1'b0;
    bus.io_fromhost_bits  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic mmio(input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd);
    int t;
    @(negedge clk);
    chk("resp_idle", {31'b0, bus.io_resp_valid}, 32'd0);
    bus.io_req_valid = 1'b1;
    bus.io_req_write = wr;
    bus.io_req_addr  = addr;
    bus.io_req_wdata = wd;
    #1;
    t = 0;
    while (!bus.io_req_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 50) begin
      chk("req_timeout", 32'd1, 32'd0);
      bus.io_req_valid = 1'b0;
      rd = 'x;
    end else begin
      @(posedge clk);
      @(negedge clk);
      bus.io_req_valid = 1'b0;
      chk("resp_valid", {31'b0, bus.io_resp_valid}, 32'd1);
      rd = bus.io_resp_rdata;
    end
  endtask

  task automatic host_push(input logic [31:0] d);
    int t;
    @(negedge clk);
    bus.io_fromhost_valid = 1'b1;
    bus.io_fromhost_bits  = d;
    #1;
    t = 0;
    while (!bus.io_fromhost_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 50) chk("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.io_fromhost_valid = 1'b0;
    chk("fh_ready_after_push", {31'b0, bus.io_fromhost_ready}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        wdog_on;
    n_chk  = 0;
    n_fail = 0;
`ifdef ZSCALE_MBOX_WDOG_EN
    wdog_on = 1'b1;
`else
    wdog_on = 1'b0;
`endif

    tbl[0]  = '{1, 32'hDEADBEEF, 0, 4'd8,  32'h0,  32'h2};
    tbl[1]  = '{0, 32'h0,        1, 4'd4,  32'h55, 32'h0};
    tbl[2]  = '{0, 32'h0,        1, 4'd8,  32'hFF, 32'h0};
    tbl[3]  = '{0, 32'h0,        1, 4'd12, 32'h77, 32'h0};
    tbl[4]  = '{0, 32'h0,        0, 4'd12, 32'h0,  32'h0};
    tbl[5]  = '{0, 32'h0,        1, 4'd0,  32'h2B, 32'h0};
    tbl[6]  = '{0, 32'h0,        0, 4'd8,  32'h0,  32'h3};
    tbl[7]  = '{0, 32'h0,        0, 4'd2,  32'h0,  32'h2B};
    tbl[8]  = '{0, 32'h0,        0, 4'd4,  32'h0,  32'hDEADBEEF};
    tbl[9]  = '{0, 32'h0,        0, 4'd4,  32'h0,  32'h0};
    tbl[10] = '{0, 32'h0,        0, 4'd8,  32'h0,  32'h1};

    do_reset();
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.io_req_ready}, 32'd1);
    chk("rst_fh_ready", {31'b0, bus.io_fromhost_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.io_resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.io_resp_rdata, 32'd0);
    chk("rst_to_valid", {31'b0, bus.io_tohost_valid}, 32'd0);
    chk("rst_to_bits", bus.io_tohost_bits, 32'd0);
    chk("rst_exit_valid", {31'b0, bus.io_exit_valid}, 32'd0);
    chk("rst_exit_code", {1'b0, bus.io_exit_code}, 32'd0);
    chk("rst_wdog", {31'b0, bus.io_wdog_fire}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].push) host_push(tbl[i].pdata);
      mmio(tbl[i].wr, BASE + {28'b0, tbl[i].off}, tbl[i].wd, rd);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
    end

    // Second TOHOST write stalls until the host pops 0x2B.
    @(negedge clk);
    bus.io_req_valid = 1'b1;
    bus.io_req_write = 1'b1;
    bus.io_req_addr  = BASE;
    bus.io_req_wdata = 32'h33;
    #1;
    chk("stall_ready_a", {31'b0, bus.io_req_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("stall_ready_b", {31'b0, bus.io_req_ready}, 32'd0);
    bus.io_tohost_ready = 1'b1;
    #1;
    chk("pop_bits", bus.io_tohost_bits, 32'h2B);
    chk("pop_cycle_ready", {31'b0, bus.io_req_ready}, 32'd0);
    @(negedge clk);
    chk("pop_to_valid", {31'b0, bus.io_tohost_valid}, 32'd0);
    chk("pop_exit_valid", {31'b0, bus.io_exit_valid}, 32'd1);
    chk("pop_exit_code", {1'b0, bus.io_exit_code}, 32'd21);
    chk("post_pop_ready", {31'b0, bus.io_req_ready}, 32'd1);
    @(negedge clk);
    bus.io_tohost_ready = 1'b0;
    bus.io_req_valid    = 1'b0;
    chk("w2_resp_valid", {31'b0, bus.io_resp_valid}, 32'd1);
    chk("w2_to_valid", {31'b0, bus.io_tohost_valid}, 32'd1);
    chk("w2_to_bits", bus.io_tohost_bits, 32'h33);
    bus.io_tohost_ready = 1'b1;
    @(negedge clk);
    bus.io_tohost_ready = 1'b0;
    chk("w2_popped", {31'b0, bus.io_tohost_valid}, 32'd0);
    chk("exit_sticky", {1'b0, bus.io_exit_code}, 32'd21);

    // Finish word 1 -> exit code 0.
    do_reset();
    mmio(1'b1, BASE, 32'h1, rd);
    chk("exit_wr_rdata", rd, 32'd0);
    chk("exit_to_bits", bus.io_tohost_bits, 32'h1);
    bus.io_tohost_ready = 1'b1;
    @(negedge clk);
    bus.io_tohost_ready = 1'b0;
    chk("exit_to_valid", {31'b0, bus.io_tohost_valid}, 32'd0);
    chk("exit1_valid", {31'b0, bus.io_exit_valid}, 32'd1);
    chk("exit1_code", {1'b0, bus.io_exit_code}, 32'd0);

    // Reset asserted while a response is pending.
    @(negedge clk);
    bus.io_req_valid = 1'b1;
    bus.io_req_write = 1'b0;
    bus.io_req_addr  = BASE + 32'd8;
    @(posedge clk);
    @(negedge clk);
    bus.io_req_valid = 1'b0;
    chk("mid_resp_valid", {31'b0, bus.io_resp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp", {31'b0, bus.io_resp_valid}, 32'd0);
    chk("mid_rst_exit", {31'b0, bus.io_exit_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, bus.io_req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Read-to-clear racing a host push: clear wins, push lands next cycle.
    host_push(32'h11);
    @(negedge clk);
    bus.io_req_valid      = 1'b1;
    bus.io_req_write      = 1'b0;
    bus.io_req_addr       = BASE + 32'd4;
    bus.io_fromhost_valid = 1'b1;
    bus.io_fromhost_bits  = 32'h22;
    @(posedge clk);
    @(negedge clk);
    bus.io_req_valid = 1'b0;
    chk("race_rdata", bus.io_resp_rdata, 32'h11);
    chk("race_fh_ready", {31'b0, bus.io_fromhost_ready}, 32'd1);
    @(negedge clk);
    bus.io_fromhost_valid = 1'b0;
    chk("race_push_late", {31'b0, bus.io_fromhost_ready}, 32'd0);
    mmio(1'b0, BASE + 32'd4, 32'h0, rd);
    chk("race_second", rd, 32'h22);

    // Watchdog: host holds off a pending word.
    do_reset();
    mmio(1'b1, BASE, 32'h2, rd);
    repeat (8) @(negedge clk);
    chk("wdog_early", {31'b0, bus.io_wdog_fire}, 32'd0);
    repeat (12) @(negedge clk);
    chk("wdog_fire", {31'b0, bus.io_wdog_fire}, {31'b0, wdog_on});
    mmio(1'b0, BASE + 32'd8, 32'h0, rd);
    chk("wdog_status", rd, wdog_on ? 32'h5 : 32'h1);
    bus.io_tohost_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.io_tohost_ready = 1'b0;
    chk("wdog_popped", {31'b0, bus.io_tohost_valid}, 32'd0);
    chk("wdog_sticky", {31'b0, bus.io_wdog_fire}, {31'b0, wdog_on});
    chk("wdog_no_exit", {31'b0, bus.io_exit_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
